// File: rtl/addsub_pkg.sv
// addsub_pkg
//   Shared definitions for the serial adder/subtractor:
//   - addsub_state_t : FSM state encoding (IDLE, BUSY, DONE)
//   - calc_steps     : number of chunk cycles for a WIDTH/CHUNK pair
//   - calc_step_w    : width of the step counter, never less than 1 bit
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    function automatic int calc_steps(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-step configuration still needs a 1-bit counter so the
    // register declaration stays legal.
    function automatic int calc_step_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk
//   Combinational CHUNK-bit full adder used once per BUSY cycle.
//   Ports:
//     a, b       : CHUNK-bit addends
//     carry_in   : carry into bit 0
//     sum        : CHUNK-bit result
//     carry_out  : carry out of the top bit
module adder_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);

    always_comb begin
        {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry_in};
    end

`ifdef FORMAL
    always_comb begin
        assert ({carry_out, sum} == ({1'b0, a} + {1'b0, b} + (CHUNK + 1)'(carry_in)));
    end
`endif

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial
//   Multi-cycle WIDTH-bit adder/subtractor that handles CHUNK bits per clock
//   through a registered ripple carry. Subtraction is done as
//   A + ~B + ~borrow_in, so the same chunk adder serves both operations.
//   Ports:
//     clk, reset_n        : rising-edge clock, asynchronous active-low reset
//     in_valid, in_ready  : operand handshake (ready only while idle)
//     a, b                : operands
//     subtract, carry_in  : operation select and carry/borrow in
//     out_valid, out_ready: result handshake (result held until taken)
//     sum                 : WIDTH-bit result
//     carry_out           : carry-out (add) / borrow-out (subtract)
//     overflow            : two's-complement signed overflow
//     zero                : sum is all zeros
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STEPS  = calc_steps(WIDTH, CHUNK);
    localparam int STEP_W = calc_step_w(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
    localparam logic [WIDTH-1:0]  CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    addsub_state_t     state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic              op_sub_q, op_sub_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;

    logic [31:0]       chunk_base;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_carry;

    // Select the current chunk with shifts so the bit position can be any
    // multiple of CHUNK without a variable part-select.
    always_comb begin
        chunk_base = 32'(step_q) * 32'(CHUNK);
        a_chunk    = CHUNK'(a_q >> chunk_base);
        b_chunk    = CHUNK'(b_q >> chunk_base);
    end

    adder_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .carry_in (carry_q),
        .sum      (chunk_sum),
        .carry_out(chunk_carry)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        op_sub_d    = op_sub_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // B and the carry are pre-inverted so BUSY only ever adds.
                    a_d      = a;
                    b_d      = subtract ? ~b : b;
                    carry_d  = subtract ? ~carry_in : carry_in;
                    op_sub_d = subtract;
                    step_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << chunk_base))
                        | (WIDTH'(chunk_sum) << chunk_base);
                carry_d = chunk_carry;
                if (step_q == LAST_STEP) begin
                    // Flags are taken from the fully assembled sum_d so they
                    // are valid in the same edge that enters DONE.
                    carry_out_d = op_sub_q ? ~chunk_carry : chunk_carry;
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
                               && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d      = (sum_d == '0);
                    step_d      = '0;
                    state_d     = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            op_sub_q    <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            op_sub_q    <= op_sub_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

`ifdef FORMAL
    // Full-width reference captured at accept, compared when DONE is entered.
    logic [WIDTH:0] ref_q;
    logic           out_valid_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_q            <= '0;
            out_valid_prev_q <= 1'b0;
        end else begin
            out_valid_prev_q <= out_valid;
            if (in_valid && in_ready) begin
                ref_q <= {1'b0, a} + {1'b0, (subtract ? ~b : b)}
                       + (WIDTH + 1)'(subtract ? ~carry_in : carry_in);
            end
        end
    end

    always_comb begin
        if (out_valid && !out_valid_prev_q) begin
            assert ({carry_out_q ^ op_sub_q, sum_q} == ref_q);
        end
    end
`endif

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle integer adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock, ripple-carrying through a registered carry. It produces a sum and carry/borrow, signed-overflow and zero flags. Operands arrive and results leave through valid/ready handshakes. It serves as the area-reduced arithmetic unit for datapaths where a full-width combinational adder is too large or too slow.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- subtract  input  1  0: A+B+carry_in; 1: A−B−carry_in (carry_in acts as borrow-in)
- carry_in  input  1  carry-in (add) / borrow-in (subtract)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry_out  output  1  carry-out (add) / borrow-out (subtract)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

## Operation
- STEPS = WIDTH/CHUNK. The FSM has 3 states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, the block latches:
  - a_reg = a; b_reg = subtract ? ~b : b
  - carry_reg = subtract ? ~carry_in : carry_in
  - op_sub = subtract; step = 0
  - State goes to BUSY.
- BUSY: each cycle adds chunk `step` of a_reg and b_reg plus carry_reg.
  - The CHUNK-bit result is written into sum bits [step*CHUNK +: CHUNK].
  - carry_reg takes the chunk carry-out; step increments.
  - After step STEPS−1 is processed, state goes to DONE.
- DONE: out_valid=1. On out_ready, state goes to IDLE.
- Flags are computed once in the final BUSY cycle and registered:
  - carry_out = op_sub ? ~final_carry : final_carry
  - overflow = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB])
  - zero = (sum == 0)
- Inputs are ignored outside IDLE; in_valid while busy is neither accepted nor queued.
- Arithmetic is modulo 2^WIDTH.

## Timing
- Reset (asynchronous, immediate, including mid-operation) clears:
  - state to IDLE; step = 0
  - all registers
  - in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, zero=0
- Latency: accept at rising edge E0 → out_valid high after edge E0+STEPS.
- Minimum spacing between accepts is STEPS+2 cycles: STEPS BUSY cycles, 1 DONE cycle, 1 IDLE cycle. IDLE and DONE are never merged.
- While out_valid && !out_ready, sum and all flags hold stable and in_ready stays 0.
- sum is only meaningful while out_valid=1; partially written values are visible during BUSY.
- When STEPS=1, BUSY lasts exactly one cycle.

## Structure
- Package `addsub_pkg` holds:
  - the `addsub_state_t` enum (IDLE, BUSY, DONE)
  - a function computing STEPS
  - the step-counter width, $clog2(STEPS) with a minimum of 1
- Sub-module `adder_chunk`: a combinational CHUNK-bit full adder (inputs a, b, carry_in; outputs sum, carry_out) instantiated once. It includes a FORMAL assertion that {carry_out, sum} == a + b + carry_in.
- Top-level FORMAL assertion: when out_valid rises, {carry, sum} matches the latched full-width reference computation.

## Test plan
- Wrap-around: WIDTH=32, CHUNK=4, add 0xFFFFFFFF + 0x00000001, cin=0 → sum=0, carry_out=1, zero=1, overflow=0. out_valid rises 8 edges after accept.
- Signed overflow: add 0x7FFFFFFF + 1 → sum=0x80000000, overflow=1, carry_out=0, zero=0.
- Subtract with borrow: a=5, b=7, subtract=1, carry_in=1 → sum=0xFFFFFFFD, carry_out=1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with other operands → outputs stable, in_ready=0 throughout. The first op completes correctly and the pulsed operands are never accepted.
- Reset mid-operation: assert reset_n=0 during the third BUSY cycle → all outputs 0 and in_ready=1 in the same cycle. After release, 0x12345678 + 0x11111111 → 0x23456789.
- Degenerate parameters: WIDTH=8, CHUNK=8, add 0x80 + 0x80 → sum=0x00, carry_out=1, overflow=1, zero=1, latency 1 cycle.
